// File: rtl/comparator_pkg.sv
// Shared definitions for the comparator: one-hot result codes and the default operand width.
package comparator_pkg;

    localparam int CMP_DEFAULT_N = 4;
    localparam int CMP_SLICE_W   = 4;

    // One-hot result codes, bit order {greater, equal, less}
    typedef enum logic [2:0] {
        CMP_LESS    = 3'b001,
        CMP_EQUAL   = 3'b010,
        CMP_GREATER = 3'b100
    } cmp_res_e;

    function automatic cmp_res_e cmp_encode(input logic lt, input logic gt);
        if (lt)
            return CMP_LESS;
        else if (gt)
            return CMP_GREATER;
        else
            return CMP_EQUAL;
    endfunction

endpackage

// File: rtl/comparator_slice.sv
// 4-bit unsigned magnitude slice producing lt/eq/gt for one nibble of the operands.
module comparator_slice
    import comparator_pkg::*;
(
    input  logic [CMP_SLICE_W-1:0] i_a,
    input  logic [CMP_SLICE_W-1:0] i_b,
    output logic                   o_lt,
    output logic                   o_eq,
    output logic                   o_gt
);

    assign o_lt = (i_a <  i_b);
    assign o_eq = (i_a == i_b);
    assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/comparator.sv
// N-bit magnitude comparator with combinational and registered results.
// Optional signed mode is enabled by defining COMPARATOR_SIGNED_EN (adds port signed_mode).
module comparator
    import comparator_pkg::*;
#(
    parameter int N = CMP_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         less,
    output logic         equal,
    output logic         greater,
    input  logic         in_valid,
`ifdef COMPARATOR_SIGNED_EN
    input  logic         signed_mode,
`endif
    output logic         less_q,
    output logic         equal_q,
    output logic         greater_q,
    output logic         out_valid
);

    localparam int NS = (N + CMP_SLICE_W - 1) / CMP_SLICE_W;
    localparam int W  = NS * CMP_SLICE_W;

    logic          w_sgn;
    logic [N-1:0]  w_a_m;
    logic [N-1:0]  w_b_m;
    logic [W-1:0]  w_a_ext;
    logic [W-1:0]  w_b_ext;
    logic [NS-1:0] w_lt;
    logic [NS-1:0] w_eq;
    logic [NS-1:0] w_gt;
    logic          w_lt_all;
    logic          w_gt_all;
    logic          w_found;
    cmp_res_e      w_res;

    logic          r_less_p1;
    logic          r_equal_p1;
    logic          r_greater_p1;
    logic          r_vld_p1;

`ifdef COMPARATOR_SIGNED_EN
    assign w_sgn = signed_mode;
`else
    assign w_sgn = 1'b0;
`endif

    // Flipping the sign bits maps two's complement order onto unsigned order
    always_comb begin
        w_a_m        = a;
        w_b_m        = b;
        w_a_m[N-1]   = a[N-1] ^ w_sgn;
        w_b_m[N-1]   = b[N-1] ^ w_sgn;
        w_a_ext      = '0;
        w_b_ext      = '0;
        w_a_ext[N-1:0] = w_a_m;
        w_b_ext[N-1:0] = w_b_m;
    end

    for (genvar g = 0; g < NS; g++) begin : g_slice
        comparator_slice u_slice (
            .i_a  (w_a_ext[g*CMP_SLICE_W +: CMP_SLICE_W]),
            .i_b  (w_b_ext[g*CMP_SLICE_W +: CMP_SLICE_W]),
            .o_lt (w_lt[g]),
            .o_eq (w_eq[g]),
            .o_gt (w_gt[g])
        );
    end

    // The most significant unequal slice decides the result
    always_comb begin
        w_lt_all = 1'b0;
        w_gt_all = 1'b0;
        w_found  = 1'b0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (!w_found && !w_eq[i]) begin
                w_lt_all = w_lt[i];
                w_gt_all = w_gt[i];
                w_found  = 1'b1;
            end
        end
    end

    assign w_res   = cmp_encode(w_lt_all, w_gt_all);
    assign less    = (w_res == CMP_LESS);
    assign equal   = (w_res == CMP_EQUAL);
    assign greater = (w_res == CMP_GREATER);

    // Stage p1: registered result, held while in_valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_less_p1    <= 1'b0;
            r_equal_p1   <= 1'b0;
            r_greater_p1 <= 1'b0;
            r_vld_p1     <= 1'b0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_less_p1    <= less;
                r_equal_p1   <= equal;
                r_greater_p1 <= greater;
            end
        end
    end

    assign less_q    = r_less_p1;
    assign equal_q   = r_equal_p1;
    assign greater_q = r_greater_p1;
    assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: N=4 and N=32 instances, vector table, corner sequences, random.
module tb_comparator;
    import comparator_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  a4, b4;
    logic        iv4;
    logic        l4, e4, g4, lq4, eq4, gq4, v4;
    logic [31:0] a32, b32;
    logic        iv32;
    logic        l32, e32, g32, lq32, eq32, gq32, v32;
    logic        sm;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model of the registered stage of the N=4 instance
    logic [2:0] m_q4;
    logic       m_v4;

    comparator #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4),
        .less(l4), .equal(e4), .greater(g4), .in_valid(iv4),
`ifdef COMPARATOR_SIGNED_EN
        .signed_mode(sm),
`endif
        .less_q(lq4), .equal_q(eq4), .greater_q(gq4), .out_valid(v4)
    );

    comparator #(.N(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32),
        .less(l32), .equal(e32), .greater(g32), .in_valid(iv32),
`ifdef COMPARATOR_SIGNED_EN
        .signed_mode(sm),
`endif
        .less_q(lq32), .equal_q(eq32), .greater_q(gq32), .out_valid(v32)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       iv;
        logic [2:0] exp;  // {less, equal, greater}
    } vec_t;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Ordering from integer values; sign bit taken as negative weight when sgn is set
    function automatic logic [2:0] ref_cmp(input longint unsigned x, input longint unsigned y,
                                           input bit sgn, input int n);
        longint sx, sy;
        sx = longint'(x);
        sy = longint'(y);
        if (sgn && ((x >> (n - 1)) & 1) == 1) sx = sx - (longint'(1) << n);
        if (sgn && ((y >> (n - 1)) & 1) == 1) sy = sy - (longint'(1) << n);
        return {sx < sy, sx == sy, sx > sy};
    endfunction

    // Drive at negedge, check comb, then check registered stage after the next posedge
    task automatic apply4(input string name, input logic [3:0] a, input logic [3:0] b,
                          input logic iv, input logic [2:0] exp);
        a4 = a; b4 = b; iv4 = iv;
        #1;
        check({name, "_comb"}, {1'b0, l4, e4, g4}, {1'b0, exp});
        @(posedge clk);
        if (iv) m_q4 = exp;
        m_v4 = iv;
        #1;
        check({name, "_reg"}, {lq4, eq4, gq4, v4}, {m_q4, m_v4});
        @(negedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{4'd8,  4'd8,  1'b1, 3'b010};
        vecs[1] = '{4'd9,  4'd8,  1'b1, 3'b001};
        vecs[2] = '{4'd0,  4'd15, 1'b1, 3'b100};
        vecs[3] = '{4'd15, 4'd15, 1'b1, 3'b010};
        vecs[4] = '{4'd0,  4'd0,  1'b1, 3'b010};
        vecs[5] = '{4'd15, 4'd0,  1'b0, 3'b001};
        vecs[6] = '{4'd7,  4'd7,  1'b1, 3'b010};
        vecs[7] = '{4'd3,  4'd5,  1'b1, 3'b100};
        vecs[8] = '{4'd6,  4'd2,  1'b0, 3'b001};
        vecs[9] = '{4'd1,  4'd14, 1'b1, 3'b100};

        rst_n = 1'b0; sm = 1'b0;
        a4 = 4'd0; b4 = 4'd0; iv4 = 1'b0;
        a32 = '0; b32 = '0; iv32 = 1'b0;
        m_q4 = 3'b000; m_v4 = 1'b0;
        #2;
        check("reset_state4", {lq4, eq4, gq4, v4}, 4'b0000);
        check("reset_state32", {lq32, eq32, gq32, v32}, 4'b0000);
        check("comb_in_reset", {1'b0, l4, e4, g4}, 4'b0010);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            apply4($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].iv, vecs[i].exp);

        // Single-cycle pulse: result held, valid drops
        a4 = 4'd3; b4 = 4'd5; iv4 = 1'b1;
        @(posedge clk); #1;
        check("pulse_capture", {lq4, eq4, gq4, v4}, 4'b1001);
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd2; iv4 = 1'b0;
        @(posedge clk); #1;
        check("pulse_hold", {lq4, eq4, gq4, v4}, 4'b1000);
        check("pulse_comb", {1'b0, l4, e4, g4}, 4'b0001);

        // Asynchronous reset between edges after a capture
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd5; iv4 = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_capture", {lq4, eq4, gq4, v4}, 4'b1001);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_regs", {lq4, eq4, gq4, v4}, 4'b0000);
        check("async_reset_comb", {1'b0, l4, e4, g4}, 4'b0100);
        @(posedge clk); #1;
        check("reset_held_edge", {lq4, eq4, gq4, v4}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        m_q4 = 3'b000; m_v4 = 1'b0;
        apply4("post_reset_first", 4'd9, 4'd2, 1'b1, 3'b001);
        apply4("post_reset_idle", 4'd2, 4'd9, 1'b0, 3'b100);

        // Random back-to-back traffic on the N=4 instance
        for (int i = 0; i < 200; i++) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom);
            rb = 4'($urandom);
            apply4("rand4", ra, rb, 1'($urandom), ref_cmp(64'(ra), 64'(rb), 1'b0, 4));
        end

        // N=32 boundaries and registered capture
        a32 = 32'h8000_0000; b32 = 32'h7FFF_FFFF; iv32 = 1'b1;
        #1;
        check("n32_msb_greater", {1'b0, l32, e32, g32}, 4'b0001);
        @(posedge clk); #1;
        check("n32_reg", {lq32, eq32, gq32, v32}, 4'b0011);
        @(negedge clk);
        iv32 = 1'b0;
        a32 = 32'h0; b32 = 32'hFFFF_FFFF; #1;
        check("n32_zero_max", {1'b0, l32, e32, g32}, 4'b0100);
        a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; #1;
        check("n32_max_max", {1'b0, l32, e32, g32}, 4'b0010);
        a32 = 32'h1234_5679; b32 = 32'h1234_5678; #1;
        check("n32_lsb_greater", {1'b0, l32, e32, g32}, 4'b0001);

        for (int i = 0; i < 1000; i++) begin
            a32 = $urandom;
            b32 = (i % 4 == 0) ? a32 ^ (32'h1 << $urandom_range(31, 0)) :
                  (i % 8 == 1) ? a32 : $urandom;
            #1;
            check("rand32", {1'b0, l32, e32, g32},
                  {1'b0, ref_cmp(64'(a32), 64'(b32), 1'b0, 32)});
        end

`ifdef COMPARATOR_SIGNED_EN
        sm = 1'b1; a4 = 4'b1000; b4 = 4'b0001; iv4 = 1'b0; #1;
        check("signed_neg8_lt_1", {1'b0, l4, e4, g4}, 4'b0100);
        sm = 1'b0; #1;
        check("unsigned_8_gt_1", {1'b0, l4, e4, g4}, 4'b0001);
        for (int i = 0; i < 300; i++) begin
            sm = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom);
            a32 = $urandom; b32 = $urandom;
            #1;
            check("rand_signed4", {1'b0, l4, e4, g4},
                  {1'b0, ref_cmp(64'(a4), 64'(b4), sm, 4)});
            check("rand_signed32", {1'b0, l32, e32, g32},
                  {1'b0, ref_cmp(64'(a32), 64'(b32), sm, 32)});
        end
        sm = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 SHALL have parameter N, default 4, operand width in bits (legal N >= 1).
REQ-002 SHALL have port clk, input, 1, rising-edge clock for the registered result stage.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port a, input, N, first operand.
REQ-005 SHALL have port b, input, N, second operand.
REQ-006 SHALL have port in_valid, input, 1, capture strobe for the registered stage.
REQ-007 SHALL have port less, output, 1, combinational a < b.
REQ-008 SHALL have port equal, output, 1, combinational a == b.
REQ-009 SHALL have port greater, output, 1, combinational a > b.
REQ-010 SHALL have port less_q, output, 1, registered less.
REQ-011 SHALL have port equal_q, output, 1, registered equal.
REQ-012 SHALL have port greater_q, output, 1, registered greater.
REQ-013 SHALL have port out_valid, output, 1, registered result valid.
REQ-014 SHALL keep the first five port positions (a, b, less, equal, greater) usable positionally after clk and rst_n.

Function
REQ-015 SHALL compare a and b as unsigned by default.
REQ-016 SHALL drive less/equal/greater combinationally, zero latency, no clock dependence.
REQ-017 SHALL assert exactly one of less/equal/greater for any defined inputs (one-hot).
REQ-018 SHALL, on a rising clk edge with in_valid=1, load less_q/equal_q/greater_q from the combinational results and set out_valid=1 (latency 1 cycle).
REQ-019 SHALL, on a rising clk edge with in_valid=0, clear out_valid and hold less_q/equal_q/greater_q.
REQ-020 SHALL treat boundaries exactly: a=b=0 and a=b=2^N-1 give equal; a=0,b=2^N-1 gives less; no wrap-around or overflow effects.
REQ-021 SHALL accept back-to-back in_valid every cycle with no bubbles or backpressure.

Reset
REQ-022 SHALL, while rst_n=0, force less_q=0, equal_q=0, greater_q=0, out_valid=0 immediately, independent of clk.
REQ-023 SHALL not affect combinational outputs by rst_n.
REQ-024 SHALL, on reset asserted mid-stream, discard any pending capture; first valid result appears one edge after the first in_valid sampled with rst_n=1.

Configuration
REQ-025 SHALL, with macro COMPARATOR_SIGNED_EN defined, add input port signed_mode (1 bit, after in_valid); signed_mode=1 compares a and b as two's complement, 0 as unsigned.
REQ-026 SHALL, without COMPARATOR_SIGNED_EN, have no signed_mode port and compare unsigned only.
REQ-027 SHALL, with signed mode and N=1, treat 1 as -1 and 0 as 0.

Structure
REQ-028 SHALL place the comparison result encoding constants (LESS, EQUAL, GREATER one-hot codes) and default width constant in shared package comparator_pkg.
REQ-029 SHALL build the magnitude compare from a sub-module comparator_slice (4-bit lt/eq/gt slice) combined MSB-first across ceil(N/4) slices, with zero-extended top slice.
REQ-030 SHALL implement signed mode by inverting operand MSBs before the unsigned slice tree.

Verification
REQ-031 N=4, a=8, b=8 -> equal=1, less=0, greater=0; in_valid=1 one edge -> equal_q=1, out_valid=1.
REQ-032 N=4, a=9, b=8 -> greater=1; a=0, b=15 -> less=1; a=15, b=15 -> equal=1.
REQ-033 N=4, in_valid pulsed one cycle with a=3,b=5 -> next edge less_q=1, out_valid=1; following edge out_valid=0, less_q stays 1.
REQ-034 rst_n driven low between edges after capture -> less_q/equal_q/greater_q/out_valid=0 immediately; combinational outputs unchanged.
REQ-035 COMPARATOR_SIGNED_EN, N=4, signed_mode=1, a=4'b1000, b=4'b0001 -> less=1; signed_mode=0 -> greater=1.
REQ-036 N=32, a=32'h8000_0000, b=32'h7FFF_FFFF unsigned -> greater=1; 1000 random pairs checked against reference model for one-hot correctness.
